ram_arbiter: RTL and testbench

- Sits directly upstream of the RAM wrapper.
- Arbitrates between the instruction-fetch port (imem) and the load/store port (dmem), and drives the single cpu_ram_if master side (ram_ren/ram_wen/ram_addr/ram_width/ram_store).
- Tracks the RAM's ram_state handshake (RAM_FREE/RAM_ADDR/RAM_DATA/RAM_ERROR) and returns a one-cycle ready pulse with captured load data to the granted requester.
- Adds a bounded-wait timeout and illegal-request detection.

---
 rtl/rv32ima_pkg.sv | 47 ++++
 rtl/ram_arb_grant.sv | 43 ++++
 rtl/ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32ima_pkg.sv
// ---------------------------------------------------------------------------
// rv32ima_pkg
// Shared types for the rv32ima memory path: the machine word, the RAM
// wrapper's handshake state and the RAM arbiter's state and port types.
// Also holds the saturating increment used by the arbiter's statistics
// counters.
// ---------------------------------------------------------------------------
package rv32ima_pkg;

    typedef logic [31:0] word_t;

    // Handshake state published by the RAM wrapper.
    typedef enum logic [1:0] {
        RAM_FREE  = 2'd0,
        RAM_ADDR  = 2'd1,
        RAM_DATA  = 2'd2,
        RAM_ERROR = 2'd3
    } ram_state_t;

    // Arbiter sequencing.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester identity.
    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } arb_port_t;

    // Instruction fetches are always full words.
    localparam logic [1:0] IMEM_WIDTH = 2'b10;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic word_t sat_inc(input word_t value);
        word_t result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// ---------------------------------------------------------------------------
// ram_arb_grant
// Combinational winner selection between the fetch and load/store ports.
//   imem_req    in   fetch port has a request pending
//   dmem_req    in   load/store port has a request pending
//   last_grant  in   port that was served most recently
//   grant_valid out  some port is requesting
//   grant_port  out  the winning port (meaningful only with grant_valid)
// DPRIO = 1 gives dmem every tie; DPRIO = 0 hands a tie to the port that
// was not served last, so neither side can starve.
// ---------------------------------------------------------------------------
module ram_arb_grant
    import rv32ima_pkg::*;
#(
    parameter logic DPRIO = 1'b1
) (
    input  logic      imem_req,
    input  logic      dmem_req,
    input  arb_port_t last_grant,
    output logic      grant_valid,
    output arb_port_t grant_port
);

    // Winner selection from the current request pair.
    always_comb begin
        grant_valid = imem_req | dmem_req;
        grant_port  = IMEM;
        if (imem_req && dmem_req) begin
            if (DPRIO) begin
                grant_port = DMEM;
            end else if (last_grant == IMEM) begin
                grant_port = DMEM;
            end else begin
                grant_port = IMEM;
            end
        end else if (dmem_req) begin
            grant_port = DMEM;
        end else begin
            grant_port = IMEM;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Arbitrates the fetch port (imem) and the load/store port (dmem) onto the
// single RAM master interface, follows the RAM's ram_state handshake and
// returns a one-cycle rdy pulse with load data and an error flag to the
// port that was served. A bounded wait aborts stuck accesses, and a
// simultaneous load+store request is rejected without touching the RAM.
//
// Ports
//   clk, rst                  clock (same as the RAM clock), async high reset
//   imem_ren/imem_addr        fetch request, held until imem_rdy
//   imem_rdy/rdata/err        one-cycle completion pulse with data and error
//   dmem_ren/wen/addr/width/wdata  load/store request, held until dmem_rdy
//   dmem_rdy/rdata/err        one-cycle completion pulse with data and error
//   ram_ren/wen/addr/width/store   RAM master side (all registered)
//   ram_load, ram_state       RAM read data and handshake state
//
// Optional build macro RAM_ARB_STATS_EN adds saturating counters on the
// ports imem_grants, dmem_grants and wait_cycles.
// ---------------------------------------------------------------------------
module ram_arbiter
    import rv32ima_pkg::*;
#(
    parameter logic       DPRIO   = 1'b1,
    parameter logic [7:0] TIMEOUT = 8'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ren,
    input  word_t       imem_addr,
    output logic        imem_rdy,
    output word_t       imem_rdata,
    output logic        imem_err,
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  word_t       dmem_addr,
    input  logic [1:0]  dmem_width,
    input  word_t       dmem_wdata,
    output logic        dmem_rdy,
    output word_t       dmem_rdata,
    output logic        dmem_err,
    output logic        ram_ren,
    output logic        ram_wen,
    output word_t       ram_addr,
    output logic [1:0]  ram_width,
    output word_t       ram_store,
    input  word_t       ram_load,
    input  logic [1:0]  ram_state
`ifdef RAM_ARB_STATS_EN
    ,
    output word_t       imem_grants,
    output word_t       dmem_grants,
    output word_t       wait_cycles
`endif
);

    arb_state_t state_r, state_nxt_s;
    arb_port_t  port_r, port_nxt_s;
    arb_port_t  last_grant_r, last_grant_nxt_s;
    logic [7:0] cnt_r, cnt_nxt_s;

    logic       ram_ren_r, ram_ren_nxt_s;
    logic       ram_wen_r, ram_wen_nxt_s;
    word_t      ram_addr_r, ram_addr_nxt_s;
    logic [1:0] ram_width_r, ram_width_nxt_s;
    word_t      ram_store_r, ram_store_nxt_s;
    logic       imem_rdy_r, imem_rdy_nxt_s;
    word_t      imem_rdata_r, imem_rdata_nxt_s;
    logic       imem_err_r, imem_err_nxt_s;
    logic       dmem_rdy_r, dmem_rdy_nxt_s;
    word_t      dmem_rdata_r, dmem_rdata_nxt_s;
    logic       dmem_err_r, dmem_err_nxt_s;

    logic       dmem_req_s;
    logic       illegal_s;
    logic       grant_valid_s;
    arb_port_t  grant_port_s;
    logic       ram_done_s;
    logic       ram_fail_s;
    logic       timeout_hit_s;
    logic       finish_s;

    assign dmem_req_s    = dmem_ren | dmem_wen;
    assign illegal_s     = dmem_ren & dmem_wen;
    assign ram_done_s    = (ram_state == RAM_DATA);
    assign ram_fail_s    = (ram_state == RAM_ERROR);
    // cnt_r counts completed ACCESS cycles, so TIMEOUT-1 marks the last one.
    assign timeout_hit_s = (TIMEOUT != 8'd0) && (cnt_r == (TIMEOUT - 8'd1));
    assign finish_s      = ram_done_s | ram_fail_s | timeout_hit_s;

    ram_arb_grant #(
        .DPRIO (DPRIO)
    ) u_grant (
        .imem_req    (imem_ren),
        .dmem_req    (dmem_req_s),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_port  (grant_port_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (illegal_s) begin
                    state_nxt_s = RESP;
                end else if (grant_valid_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (finish_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, the wait counter and grant history.
    always_comb begin
        ram_ren_nxt_s    = ram_ren_r;
        ram_wen_nxt_s    = ram_wen_r;
        ram_addr_nxt_s   = ram_addr_r;
        ram_width_nxt_s  = ram_width_r;
        ram_store_nxt_s  = ram_store_r;
        imem_rdy_nxt_s   = 1'b0;
        imem_rdata_nxt_s = imem_rdata_r;
        imem_err_nxt_s   = imem_err_r;
        dmem_rdy_nxt_s   = 1'b0;
        dmem_rdata_nxt_s = dmem_rdata_r;
        dmem_err_nxt_s   = dmem_err_r;
        port_nxt_s       = port_r;
        last_grant_nxt_s = last_grant_r;
        cnt_nxt_s        = cnt_r;
        case (state_r)
            IDLE: begin
                if (illegal_s) begin
                    // Rejected outright; the RAM never sees it.
                    port_nxt_s     = DMEM;
                    dmem_rdy_nxt_s = 1'b1;
                    dmem_err_nxt_s = 1'b1;
                end else if (grant_valid_s) begin
                    port_nxt_s = grant_port_s;
                    if (grant_port_s == DMEM) begin
                        ram_ren_nxt_s   = dmem_ren;
                        ram_wen_nxt_s   = dmem_wen;
                        ram_addr_nxt_s  = dmem_addr;
                        ram_width_nxt_s = dmem_width;
                        ram_store_nxt_s = dmem_wdata;
                        dmem_err_nxt_s  = 1'b0;
                    end else begin
                        ram_ren_nxt_s   = 1'b1;
                        ram_wen_nxt_s   = 1'b0;
                        ram_addr_nxt_s  = imem_addr;
                        ram_width_nxt_s = IMEM_WIDTH;
                        ram_store_nxt_s = 32'd0;
                        imem_err_nxt_s  = 1'b0;
                    end
                end else begin
                    port_nxt_s = port_r;
                end
            end
            ACCESS: begin
                cnt_nxt_s = cnt_r + 8'd1;
                if (finish_s) begin
                    ram_ren_nxt_s = 1'b0;
                    ram_wen_nxt_s = 1'b0;
                    if (port_r == DMEM) begin
                        dmem_rdy_nxt_s = 1'b1;
                        dmem_err_nxt_s = ~ram_done_s;
                        if (ram_done_s) begin
                            // Stores return no data.
                            dmem_rdata_nxt_s = ram_wen_r ? 32'd0 : ram_load;
                        end else begin
                            dmem_rdata_nxt_s = dmem_rdata_r;
                        end
                    end else begin
                        imem_rdy_nxt_s = 1'b1;
                        imem_err_nxt_s = ~ram_done_s;
                        if (ram_done_s) begin
                            imem_rdata_nxt_s = ram_load;
                        end else begin
                            imem_rdata_nxt_s = imem_rdata_r;
                        end
                    end
                end else begin
                    ram_ren_nxt_s = ram_ren_r;
                end
            end
            RESP: begin
                last_grant_nxt_s = port_r;
                cnt_nxt_s        = 8'd0;
            end
            default: begin
                cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ren_r    <= 1'b0;
            ram_wen_r    <= 1'b0;
            ram_addr_r   <= 32'd0;
            ram_width_r  <= 2'd0;
            ram_store_r  <= 32'd0;
            imem_rdy_r   <= 1'b0;
            imem_rdata_r <= 32'd0;
            imem_err_r   <= 1'b0;
            dmem_rdy_r   <= 1'b0;
            dmem_rdata_r <= 32'd0;
            dmem_err_r   <= 1'b0;
            port_r       <= IMEM;
            last_grant_r <= IMEM;
            cnt_r        <= 8'd0;
        end else begin
            ram_ren_r    <= ram_ren_nxt_s;
            ram_wen_r    <= ram_wen_nxt_s;
            ram_addr_r   <= ram_addr_nxt_s;
            ram_width_r  <= ram_width_nxt_s;
            ram_store_r  <= ram_store_nxt_s;
            imem_rdy_r   <= imem_rdy_nxt_s;
            imem_rdata_r <= imem_rdata_nxt_s;
            imem_err_r   <= imem_err_nxt_s;
            dmem_rdy_r   <= dmem_rdy_nxt_s;
            dmem_rdata_r <= dmem_rdata_nxt_s;
            dmem_err_r   <= dmem_err_nxt_s;
            port_r       <= port_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    assign ram_ren    = ram_ren_r;
    assign ram_wen    = ram_wen_r;
    assign ram_addr   = ram_addr_r;
    assign ram_width  = ram_width_r;
    assign ram_store  = ram_store_r;
    assign imem_rdy   = imem_rdy_r;
    assign imem_rdata = imem_rdata_r;
    assign imem_err   = imem_err_r;
    assign dmem_rdy   = dmem_rdy_r;
    assign dmem_rdata = dmem_rdata_r;
    assign dmem_err   = dmem_err_r;

`ifdef RAM_ARB_STATS_EN
    word_t imem_grants_r, dmem_grants_r, wait_cycles_r;
    logic  imem_win_s, dmem_win_s, imem_wait_s, dmem_wait_s;

    assign dmem_win_s  = (state_r == IDLE) &&
                         (illegal_s || (grant_valid_s && (grant_port_s == DMEM)));
    assign imem_win_s  = (state_r == IDLE) && !illegal_s && grant_valid_s &&
                         (grant_port_s == IMEM);
    // A port is waiting when it requests but is neither winning now nor in service.
    assign imem_wait_s = imem_ren && !imem_win_s &&
                         !((state_r != IDLE) && (port_r == IMEM));
    assign dmem_wait_s = dmem_req_s && !dmem_win_s &&
                         !((state_r != IDLE) && (port_r == DMEM));

    // Saturating grant and wait statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_grants_r <= 32'd0;
            dmem_grants_r <= 32'd0;
            wait_cycles_r <= 32'd0;
        end else begin
            imem_grants_r <= imem_win_s ? sat_inc(imem_grants_r) : imem_grants_r;
            dmem_grants_r <= dmem_win_s ? sat_inc(dmem_grants_r) : dmem_grants_r;
            wait_cycles_r <= (imem_wait_s || dmem_wait_s) ? sat_inc(wait_cycles_r)
                                                          : wait_cycles_r;
        end
    end

    assign imem_grants = imem_grants_r;
    assign dmem_grants = dmem_grants_r;
    assign wait_cycles = wait_cycles_r;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter. Instance 0 runs DPRIO=1 with TIMEOUT=4,
// instance 1 runs DPRIO=0 with the default TIMEOUT. Each instance has a
// small RAM model: FREE -> ADDR on an enable, ADDR -> DATA (or stays in ADDR,
// or goes to ERROR, depending on mode), back to FREE once enables drop.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
    import rv32ima_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  imem_ren, dmem_ren, dmem_wen;
    logic [31:0] imem_addr [2];
    logic [31:0] dmem_addr [2];
    logic [31:0] dmem_wdata [2];
    logic [1:0]  dmem_width [2];
    logic [31:0] ram_load [2];
    logic [1:0]  rs [2];
    logic [1:0]  mode [2];

    wire  [1:0]  imem_rdy, imem_err, dmem_rdy, dmem_err, ram_ren, ram_wen;
    wire  [31:0] imem_rdata [2];
    wire  [31:0] dmem_rdata [2];
    wire  [31:0] ram_addr [2];
    wire  [31:0] ram_store [2];
    wire  [1:0]  ram_width [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_arbiter #(
            .DPRIO   ((g == 0) ? 1'b1 : 1'b0),
            .TIMEOUT ((g == 0) ? 8'd4 : 8'd32)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .imem_ren   (imem_ren[g]),
            .imem_addr  (imem_addr[g]),
            .imem_rdy   (imem_rdy[g]),
            .imem_rdata (imem_rdata[g]),
            .imem_err   (imem_err[g]),
            .dmem_ren   (dmem_ren[g]),
            .dmem_wen   (dmem_wen[g]),
            .dmem_addr  (dmem_addr[g]),
            .dmem_width (dmem_width[g]),
            .dmem_wdata (dmem_wdata[g]),
            .dmem_rdy   (dmem_rdy[g]),
            .dmem_rdata (dmem_rdata[g]),
            .dmem_err   (dmem_err[g]),
            .ram_ren    (ram_ren[g]),
            .ram_wen    (ram_wen[g]),
            .ram_addr   (ram_addr[g]),
            .ram_width  (ram_width[g]),
            .ram_store  (ram_store[g]),
            .ram_load   (ram_load[g]),
            .ram_state  (rs[g])
        );
    end

    // RAM handshake model for both instances (mode 0 ok, 1 hang, 2 error).
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rs[d] <= RAM_FREE;
            end else if (!(ram_ren[d] | ram_wen[d])) begin
                rs[d] <= RAM_FREE;
            end else begin
                case (rs[d])
                    RAM_FREE: rs[d] <= RAM_ADDR;
                    RAM_ADDR: rs[d] <= (mode[d] == 2'd1) ? RAM_ADDR :
                                       (mode[d] == 2'd2) ? RAM_ERROR : RAM_DATA;
                    default:  rs[d] <= rs[d];
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns the cycle index at which rdy is seen (0 if never within budget).
    task automatic wait_rdy(input int d, input bit dport, input int start, output int cyc);
        bit done;
        done = 1'b0;
        cyc  = 0;
        for (int i = start; i <= 40; i++) begin
            if (!done) begin
                if ((dport ? dmem_rdy[d] : imem_rdy[d]) == 1'b1) begin
                    cyc  = i;
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic one_load(input int d, input bit dport, input logic [31:0] addr,
                            input logic [31:0] val, input logic exp_err, input string tag);
        int cyc;
        ram_load[d] = val;
        if (dport) begin
            dmem_addr[d]  = addr;
            dmem_width[d] = 2'b10;
            dmem_ren[d]   = 1'b1;
        end else begin
            imem_addr[d] = addr;
            imem_ren[d]  = 1'b1;
        end
        @(negedge clk);
        check({tag, "_ren"}, ram_ren[d], 1'b1);
        check({tag, "_addr"}, ram_addr[d], addr);
        check({tag, "_width"}, ram_width[d], 2'b10);
        check({tag, "_errclr"}, dport ? dmem_err[d] : imem_err[d], 1'b0);
        wait_rdy(d, dport, 1, cyc);
        check({tag, "_lat"}, cyc, 32'd4);
        check({tag, "_err"}, dport ? dmem_err[d] : imem_err[d], exp_err);
        if (!exp_err) begin
            check({tag, "_rdata"}, dport ? dmem_rdata[d] : imem_rdata[d], val);
        end
        check({tag, "_ren_off"}, ram_ren[d], 1'b0);
        if (dport) dmem_ren[d] = 1'b0;
        else imem_ren[d] = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, dport ? dmem_rdy[d] : imem_rdy[d], 1'b0);
    endtask

    task automatic dual(input int d, input bit dmem_first, input string tag);
        int cyc, ic, dc;
        cyc = 1;
        ic  = 0;
        dc  = 0;
        imem_addr[d]  = 32'h0000_0200;
        dmem_addr[d]  = 32'h0000_0300;
        dmem_width[d] = 2'b10;
        ram_load[d]   = 32'h1111_2222;
        imem_ren[d]   = 1'b1;
        dmem_ren[d]   = 1'b1;
        @(negedge clk);
        check({tag, "_first_addr"}, ram_addr[d], dmem_first ? 32'h0000_0300 : 32'h0000_0200);
        while (cyc < 40 && (ic == 0 || dc == 0)) begin
            if (imem_rdy[d] && ic == 0) begin
                ic = cyc;
                imem_ren[d] = 1'b0;
                check({tag, "_imem_rdata"}, imem_rdata[d], 32'h1111_2222);
            end
            if (dmem_rdy[d] && dc == 0) begin
                dc = cyc;
                dmem_ren[d] = 1'b0;
                check({tag, "_dmem_rdata"}, dmem_rdata[d], 32'h1111_2222);
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_dmem_lat"}, dc, dmem_first ? 32'd4 : 32'd9);
        check({tag, "_imem_lat"}, ic, dmem_first ? 32'd9 : 32'd4);
    endtask

    initial begin
        int cyc;
        int pulses;
        rst      = 1'b1;
        imem_ren = 2'b00;
        dmem_ren = 2'b00;
        dmem_wen = 2'b00;
        for (int d = 0; d < 2; d++) begin
            imem_addr[d]  = 32'd0;
            dmem_addr[d]  = 32'd0;
            dmem_wdata[d] = 32'd0;
            dmem_width[d] = 2'b00;
            ram_load[d]   = 32'd0;
            mode[d]       = 2'd0;
        end
        repeat (2) @(negedge clk);
        check("rst_imem_rdy", imem_rdy[0], 1'b0);
        check("rst_dmem_rdy", dmem_rdy[0], 1'b0);
        check("rst_ram_ren", ram_ren[0], 1'b0);
        check("rst_ram_wen", ram_wen[0], 1'b0);
        check("rst_ram_addr", ram_addr[0], 32'd0);
        check("rst_imem_rdata", imem_rdata[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ram_ren", ram_ren[0], 1'b0);

        // Plain fetch.
        one_load(0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, "fetch");
        check("fetch_hold", imem_rdata[0], 32'hDEAD_BEEF);

        // Simultaneous requests, dmem priority.
        dual(0, 1'b1, "prio1");

        // Half-word store: master side stable until RAM_DATA, no load data.
        dmem_addr[0]  = 32'h0000_0040;
        dmem_width[0] = 2'b01;
        dmem_wdata[0] = 32'h0000_1234;
        dmem_wen[0]   = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            check("st_wen", ram_wen[0], 1'b1);
            check("st_ren", ram_ren[0], 1'b0);
            check("st_addr", ram_addr[0], 32'h0000_0040);
            check("st_width", ram_width[0], 2'b01);
            check("st_store", ram_store[0], 32'h0000_1234);
            @(negedge clk);
        end
        wait_rdy(0, 1'b1, 4, cyc);
        check("st_lat", cyc, 32'd4);
        check("st_err", dmem_err[0], 1'b0);
        check("st_rdata", dmem_rdata[0], 32'd0);
        dmem_wen[0] = 1'b0;
        @(negedge clk);

        // Load and store together: immediate error, RAM untouched.
        dmem_addr[0] = 32'h0000_0080;
        dmem_ren[0]  = 1'b1;
        dmem_wen[0]  = 1'b1;
        @(negedge clk);
        check("ill_rdy", dmem_rdy[0], 1'b1);
        check("ill_err", dmem_err[0], 1'b1);
        check("ill_en", {ram_ren[0], ram_wen[0]}, 2'b00);
        dmem_ren[0] = 1'b0;
        dmem_wen[0] = 1'b0;
        @(negedge clk);
        check("ill_pulse", dmem_rdy[0], 1'b0);
        check("ill_en_after", {ram_ren[0], ram_wen[0]}, 2'b00);
        one_load(0, 1'b1, 32'h0000_0084, 32'hCAFE_F00D, 1'b0, "after_ill");

        // RAM stuck in RAM_ADDR: abort after TIMEOUT=4 access cycles.
        mode[0]      = 2'd1;
        imem_addr[0] = 32'h0000_0300;
        imem_ren[0]  = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            check("to_ren_held", ram_ren[0], 1'b1);
            check("to_no_rdy", imem_rdy[0], 1'b0);
            @(negedge clk);
        end
        check("to_ren_drop", ram_ren[0], 1'b0);
        check("to_rdy", imem_rdy[0], 1'b1);
        check("to_err", imem_err[0], 1'b1);
        imem_ren[0] = 1'b0;
        mode[0]     = 2'd0;
        @(negedge clk);

        // RAM reports RAM_ERROR.
        mode[0] = 2'd2;
        one_load(0, 1'b0, 32'h0000_0310, 32'h5555_AAAA, 1'b1, "ramerr");
        mode[0] = 2'd0;

        // Reset in the middle of an access.
        imem_addr[0] = 32'h0000_0500;
        ram_load[0]  = 32'h0BAD_F00D;
        imem_ren[0]  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pre_ren", ram_ren[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ren", ram_ren[0], 1'b0);
        imem_ren[0] = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(imem_rdy[0]);
        end
        check("rst_no_rdy", pulses, 32'd0);
        one_load(0, 1'b0, 32'h0000_0504, 32'h7777_8888, 1'b0, "post_rst");

        // Alternating priority on instance 1.
        dual(1, 1'b1, "alt_a");
        one_load(1, 1'b1, 32'h0000_0600, 32'h9999_0000, 1'b0, "alt_dmem");
        dual(1, 1'b0, "alt_b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
